// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into the configuration chain loader.
// The host drives data/valid; the loader answers with ready.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB-first into a configuration flip-flop chain.
// An optional verify pass compares the returning chain tail against the re-sent stream.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                start,
    input  logic                verify,
    ccff_chain_loader_if.slave  bitstream,
    output logic                ccff_head,
    output logic                ccff_shift_en,
    input  logic                ccff_tail,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int              WB_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [WB_W-1:0] LAST_WBIT = WB_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              verify_q;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WB_W-1:0]   wbit;
    logic              ready;
    logic              load_word;
    logic              advance;
    logic              pass_end;
    logic              word_end;

    // bit_cnt counts bits already shifted; the current head bit is the last when it equals LAST_BIT
    assign pass_end = (bit_cnt == LAST_BIT);
    assign word_end = (wbit == LAST_WBIT);
    assign advance  = (state == SHIFT) && !pass_end && !word_end;

    assign bitstream.s_ready = ready;
    assign busy              = (state != IDLE);
    assign done              = (state == DONE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        ready     = 1'b0;
        load_word = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                ready = 1'b1;
                if (bitstream.s_valid) begin
                    load_word = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (pass_end) begin
                    state_nxt = DONE;
                end else if (word_end) begin
                    ready = 1'b1;
                    if (bitstream.s_valid) load_word = 1'b1;
                    else                   state_nxt = FETCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!pReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            verify_q      <= 1'b0;
            shreg         <= '0;
            bit_cnt       <= '0;
            wbit          <= '0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            err           <= 1'b0;
            err_cnt       <= '0;
        end else begin
            if (state == IDLE && start) begin
                verify_q <= verify;
                err      <= 1'b0;
                err_cnt  <= '0;
                bit_cnt  <= '0;
            end

            // On a stall the head simply holds its last bit until the next word lands
            if (load_word) begin
                ccff_head <= bitstream.s_data[WORD_W-1];
                shreg     <= bitstream.s_data << 1;
                wbit      <= '0;
            end else if (advance) begin
                ccff_head <= shreg[WORD_W-1];
                shreg     <= shreg << 1;
                wbit      <= wbit + 1'b1;
            end

            ccff_shift_en <= load_word || advance;

            if (ccff_shift_en) bit_cnt <= bit_cnt + 1'b1;

            if (verify_q && ccff_shift_en && (ccff_tail != ccff_head)) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: an 8-bit loader driving a modelled 8-deep chain, plus a 12-bit
// loader exercising the stalled, partial final word.
module tb_ccff_chain_loader;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        start8, verify8, start12, verify12;
    logic        head8, shift_en8, busy8, done8, err8;
    logic        head12, shift_en12, busy12, done12, err12;
    logic [15:0] err_cnt8, err_cnt12;
    logic [7:0]  chain;
    logic        flip_req;
    int          hs8 = 0;
    int          hs12 = 0;
    int          sh12 = 0;
    int          checks = 0;
    int          errors = 0;

    ccff_chain_loader_if #(.WORD_W(8)) bus8 ();
    ccff_chain_loader_if #(.WORD_W(8)) bus12 ();

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .CNT_W(16)) dut8 (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start8),
        .verify       (verify8),
        .bitstream    (bus8),
        .ccff_head    (head8),
        .ccff_shift_en(shift_en8),
        .ccff_tail    (chain[7]),
        .busy         (busy8),
        .done         (done8),
        .err          (err8),
        .err_cnt      (err_cnt8)
    );

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(16)) dut12 (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start12),
        .verify       (verify12),
        .bitstream    (bus12),
        .ccff_head    (head12),
        .ccff_shift_en(shift_en12),
        .ccff_tail    (1'b0),
        .busy         (busy12),
        .done         (done12),
        .err          (err12),
        .err_cnt      (err_cnt12)
    );

    // Chain model: chain[0] sits after ccff_head, chain[7] drives ccff_tail
    always @(posedge prog_clk) begin
        if (shift_en8 === 1'b1)   chain <= {chain[6:0], head8};
        else if (flip_req)        chain[3] <= ~chain[3];
    end

    always @(posedge prog_clk) begin
        if (bus8.s_valid === 1'b1 && bus8.s_ready === 1'b1)   hs8  <= hs8 + 1;
        if (bus12.s_valid === 1'b1 && bus12.s_ready === 1'b1) hs12 <= hs12 + 1;
        if (shift_en12 === 1'b1)                              sh12 <= sh12 + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge prog_clk);
        #1;
    endtask

    // Full pass on the 8-bit loader; ends one cycle after done, back in IDLE
    task automatic run_pass8(input logic [7:0] w, input logic vfy);
        logic seen;
        start8  = 1'b1;
        verify8 = vfy;
        tick();
        start8       = 1'b0;
        bus8.s_valid = 1'b1;
        bus8.s_data  = w;
        tick();
        bus8.s_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) seen = 1'b1;
            else       tick();
        end
        check("pass8_done_seen", {31'd0, seen}, 32'd1);
        tick();
    endtask

    initial begin
        logic [7:0] w;
        int         hs0;
        int         dones;

        flip_req      = 1'b0;
        pReset        = 1'b0;
        start8        = 1'b1;
        verify8       = 1'b0;
        start12       = 1'b1;
        verify12      = 1'b0;
        bus8.s_valid  = 1'b1;
        bus8.s_data   = 8'hFF;
        bus12.s_valid = 1'b1;
        bus12.s_data  = 8'hFF;

        // Reset dominates start and s_valid
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_busy",     {31'd0, busy8},        32'd0);
            check("rst_done",     {31'd0, done8},        32'd0);
            check("rst_shift_en", {31'd0, shift_en8},    32'd0);
            check("rst_head",     {31'd0, head8},        32'd0);
            check("rst_ready",    {31'd0, bus8.s_ready}, 32'd0);
            check("rst_err",      {31'd0, err8},         32'd0);
            check("rst_err_cnt",  {16'd0, err_cnt8},     32'd0);
            check("rst_ready12",  {31'd0, bus12.s_ready}, 32'd0);
            check("rst_busy12",   {31'd0, busy12},       32'd0);
        end
        pReset        = 1'b1;
        start8        = 1'b0;
        start12       = 1'b0;
        bus8.s_valid  = 1'b0;
        bus12.s_valid = 1'b0;
        tick();

        // Load 0xA5, no stalls: shifts on cycles 2..9, done on cycle 10
        w      = 8'hA5;
        start8 = 1'b1;
        check("a5_ready_c0", {31'd0, bus8.s_ready}, 32'd0);
        tick();
        start8 = 1'b0;
        check("a5_ready_c1", {31'd0, bus8.s_ready}, 32'd1);
        check("a5_busy_c1",  {31'd0, busy8},        32'd1);
        check("a5_shen_c1",  {31'd0, shift_en8},    32'd0);
        bus8.s_valid = 1'b1;
        bus8.s_data  = w;
        tick();
        bus8.s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("a5_shift_en", {31'd0, shift_en8},    32'd1);
            check("a5_head",     {31'd0, head8},        {31'd0, w[7-k]});
            check("a5_ready",    {31'd0, bus8.s_ready}, 32'd0);
            check("a5_done",     {31'd0, done8},        32'd0);
            tick();
        end
        check("a5_done_c10",  {31'd0, done8},     32'd1);
        check("a5_shen_c10",  {31'd0, shift_en8}, 32'd0);
        check("a5_busy_c10",  {31'd0, busy8},     32'd1);
        tick();
        check("a5_done_c11",  {31'd0, done8},     32'd0);
        check("a5_busy_c11",  {31'd0, busy8},     32'd0);
        check("a5_chain",     {24'd0, chain},     32'h0000_00A5);

        // 12-bit chain: 0xF0 at once, 0xC0 held off 3 cycles, top 4 bits of 0xC0 used
        start12 = 1'b1;
        tick();
        start12 = 1'b0;
        check("st_ready_c1", {31'd0, bus12.s_ready}, 32'd1);
        bus12.s_valid = 1'b1;
        bus12.s_data  = 8'hF0;
        tick();
        bus12.s_valid = 1'b0;
        w = 8'hF0;
        for (int k = 0; k < 8; k++) begin
            check("st_w0_shift_en", {31'd0, shift_en12}, 32'd1);
            check("st_w0_head",     {31'd0, head12},     {31'd0, w[7-k]});
            check("st_w0_ready",    {31'd0, bus12.s_ready}, (k == 7) ? 32'd1 : 32'd0);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            check("st_stall_shift_en", {31'd0, shift_en12},    32'd0);
            check("st_stall_head",     {31'd0, head12},        32'd0);
            check("st_stall_ready",    {31'd0, bus12.s_ready}, 32'd1);
            check("st_stall_busy",     {31'd0, busy12},        32'd1);
            if (j == 2) begin
                bus12.s_valid = 1'b1;
                bus12.s_data  = 8'hC0;
            end
            tick();
        end
        // An extra word is offered; the loader must not take it
        bus12.s_data = 8'hFF;
        w = 8'hC0;
        for (int k = 0; k < 4; k++) begin
            check("st_w1_shift_en", {31'd0, shift_en12},    32'd1);
            check("st_w1_head",     {31'd0, head12},        {31'd0, w[7-k]});
            check("st_w1_ready",    {31'd0, bus12.s_ready}, 32'd0);
            tick();
        end
        check("st_done",      {31'd0, done12},     32'd1);
        check("st_shen_done", {31'd0, shift_en12}, 32'd0);
        bus12.s_valid = 1'b0;
        tick();
        check("st_busy_end",  {31'd0, busy12}, 32'd0);
        check("st_words",     hs12,            32'd2);
        check("st_shifts",    sh12,            32'd12);

        // Load then verify the same stream: clean
        run_pass8(8'h3C, 1'b0);
        check("v_chain_load", {24'd0, chain},    32'h0000_003C);
        run_pass8(8'h3C, 1'b1);
        check("v_clean_err",     {31'd0, err8},    32'd0);
        check("v_clean_err_cnt", {16'd0, err_cnt8}, 32'd0);
        check("v_chain_verify",  {24'd0, chain},   32'h0000_003C);

        // Corrupt one chain flop, verify again: exactly one mismatch
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        check("v_chain_flipped", {24'd0, chain}, 32'h0000_0034);
        run_pass8(8'h3C, 1'b1);
        check("v_bad_err",     {31'd0, err8},     32'd1);
        check("v_bad_err_cnt", {16'd0, err_cnt8}, 32'd1);
        check("v_chain_fixed", {24'd0, chain},    32'h0000_003C);

        // Reset in the middle of a pass, then reload
        start8  = 1'b1;
        verify8 = 1'b0;
        tick();
        start8       = 1'b0;
        bus8.s_valid = 1'b1;
        bus8.s_data  = 8'h96;
        check("mr_err_cleared", {31'd0, err8},     32'd0);
        check("mr_cnt_cleared", {16'd0, err_cnt8}, 32'd0);
        tick();
        bus8.s_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mr_shifting", {31'd0, shift_en8}, 32'd1);
        pReset = 1'b0;
        tick();
        check("mr_shen_after", {31'd0, shift_en8}, 32'd0);
        check("mr_busy_after", {31'd0, busy8},     32'd0);
        check("mr_done_after", {31'd0, done8},     32'd0);
        pReset = 1'b1;
        run_pass8(8'h69, 1'b0);
        check("mr_chain_reload", {24'd0, chain}, 32'h0000_0069);
        check("mr_load_no_err",  {31'd0, err8},  32'd0);

        // s_valid in IDLE and start while busy are ignored
        hs0          = hs8;
        bus8.s_valid = 1'b1;
        bus8.s_data  = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            check("ig_idle_ready", {31'd0, bus8.s_ready}, 32'd0);
            check("ig_idle_busy",  {31'd0, busy8},        32'd0);
            tick();
        end
        check("ig_idle_words", hs8 - hs0, 32'd0);
        bus8.s_valid = 1'b0;
        start8       = 1'b1;
        tick();
        start8       = 1'b0;
        check("ig_ready_c1", {31'd0, bus8.s_ready}, 32'd1);
        bus8.s_valid = 1'b1;
        bus8.s_data  = 8'h5A;
        tick();
        bus8.s_data = 8'hFF;
        dones = 0;
        for (int i = 0; i < 13; i++) begin
            start8 = (i == 1);
            if (done8) dones++;
            tick();
        end
        start8       = 1'b0;
        bus8.s_valid = 1'b0;
        check("ig_single_done", dones,           32'd1);
        check("ig_words",       hs8 - hs0,       32'd1);
        check("ig_chain",       {24'd0, chain},  32'h0000_005A);
        check("ig_busy_end",    {31'd0, busy8},  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
